// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative IEEE-754 single divider, one quotient bit per clock.
// Define FDIV_RNE_EN for round-to-nearest-even; default build truncates.
module fdiv_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   output logic        busy,
   output logic        valid,
   output logic [31:0] out_div,
   output logic [3:0]  flags
);

   localparam int QBITS = 26;

`ifdef FDIV_RNE_EN
   localparam logic RNE = 1'b1;
`else
   localparam logic RNE = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_ROUND
   } state_t;

   state_t r_state;
   state_t w_state_n;

   logic               r_sign;
   logic [23:0]        r_mb;
   logic [25:0]        r_rem;
   logic [25:0]        r_q;
   logic [4:0]         r_cnt;
   logic signed [9:0]  r_exp;
   logic               r_spec;
   logic [31:0]        r_spec_res;
   logic [3:0]         r_spec_flg;
   logic               r_valid;
   logic [31:0]        r_out;
   logic [3:0]         r_flags;

   logic [7:0]         w_e1;
   logic [7:0]         w_e2;
   logic               w_z1;
   logic               w_z2;
   logic               w_i1;
   logic               w_i2;
   logic               w_n1;
   logic               w_n2;
   logic               w_sign;
   logic [23:0]        w_ma;
   logic [23:0]        w_mb;
   logic signed [9:0]  w_exp0;
   logic               w_spec;
   logic [31:0]        w_spec_res;
   logic [3:0]         w_spec_flg;

   assign w_e1   = num1[30:23];
   assign w_e2   = num2[30:23];
   assign w_z1   = (w_e1 == 8'h00);
   assign w_z2   = (w_e2 == 8'h00);
   assign w_i1   = (w_e1 == 8'hFF) && (num1[22:0] == 23'h0);
   assign w_i2   = (w_e2 == 8'hFF) && (num2[22:0] == 23'h0);
   assign w_n1   = (w_e1 == 8'hFF) && (num1[22:0] != 23'h0);
   assign w_n2   = (w_e2 == 8'hFF) && (num2[22:0] != 23'h0);
   assign w_sign = num1[31] ^ num2[31];
   // Denormal operands are flushed to zero, so their significand is dropped.
   assign w_ma   = w_z1 ? 24'h0 : {1'b1, num1[22:0]};
   assign w_mb   = w_z2 ? 24'h0 : {1'b1, num2[22:0]};
   assign w_exp0 = $signed({2'b00, w_e1} - {2'b00, w_e2} + 10'd127);

   always_comb begin
      w_spec     = 1'b1;
      w_spec_res = 32'h0;
      w_spec_flg = 4'h0;
      if (w_n1 || w_n2) begin
         w_spec_res = 32'h7FC00000;
      end else if ((w_z1 && w_z2) || (w_i1 && w_i2)) begin
         w_spec_res = 32'h7FC00000;
         w_spec_flg = 4'b1000;
      end else if (w_z2 && !w_i1) begin
         w_spec_res = {w_sign, 8'hFF, 23'h0};
         w_spec_flg = 4'b0100;
      end else if (w_i1) begin
         w_spec_res = {w_sign, 8'hFF, 23'h0};
      end else if (w_z1 || w_i2) begin
         w_spec_res = {w_sign, 31'h0};
      end else begin
         w_spec = 1'b0;
      end
   end

   // Compare before shifting so q[25] is the integer bit of ma/mb.
   logic        w_ge;
   logic [25:0] w_sub;
   logic [25:0] w_rem_n;

   assign w_ge    = (r_rem >= {2'b00, r_mb});
   assign w_sub   = r_rem - {2'b00, r_mb};
   assign w_rem_n = (w_ge ? w_sub : r_rem) << 1;

   logic               w_norm;
   logic [23:0]        w_mant;
   logic               w_g;
   logic               w_s;
   logic               w_up;
   logic [24:0]        w_sum;
   logic signed [9:0]  w_exp_n;
   logic signed [9:0]  w_exp_r;
   logic [30:0]        w_mag;
   logic [31:0]        w_res;
   logic [3:0]         w_flg;

   assign w_norm  = r_q[25];
   assign w_mant  = w_norm ? r_q[25:2] : r_q[24:1];
   assign w_g     = w_norm ? r_q[1] : r_q[0];
   assign w_s     = (w_norm & r_q[0]) | (r_rem != 26'h0);
   assign w_exp_n = w_norm ? r_exp : r_exp - 10'sd1;
   assign w_up    = RNE & w_g & (w_s | w_mant[0]);
   assign w_sum   = {1'b0, w_mant} + {24'h0, w_up};
   assign w_exp_r = w_exp_n + $signed({9'h0, w_sum[24]});
   // Hidden bit (or rounding carry) lands on the exponent field.
   assign w_mag   = 31'({w_exp_n - 10'd1, 23'h0} + {8'h0, w_sum});

   always_comb begin
      w_res = {r_sign, w_mag};
      w_flg = 4'h0;
      if (w_exp_r >= 10'sd255) begin
         w_res = {r_sign, 8'hFF, 23'h0};
         w_flg = 4'b0010;
      end else if (w_exp_r <= 10'sd0) begin
         w_res = {r_sign, 31'h0};
         w_flg = 4'b0001;
      end
   end

   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_n = S_DIV;
         S_DIV:   if (r_cnt == 5'(QBITS - 1)) w_state_n = S_ROUND;
         S_ROUND: w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sign     <= 1'b0;
         r_mb       <= 24'h0;
         r_rem      <= 26'h0;
         r_q        <= 26'h0;
         r_cnt      <= 5'h0;
         r_exp      <= 10'sd0;
         r_spec     <= 1'b0;
         r_spec_res <= 32'h0;
         r_spec_flg <= 4'h0;
         r_valid    <= 1'b0;
         r_out      <= 32'h0;
         r_flags    <= 4'h0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sign     <= w_sign;
                  r_rem      <= {2'b00, w_ma};
                  r_mb       <= w_mb;
                  r_q        <= 26'h0;
                  r_cnt      <= 5'h0;
                  r_exp      <= w_exp0;
                  r_spec     <= w_spec;
                  r_spec_res <= w_spec_res;
                  r_spec_flg <= w_spec_flg;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_n;
               r_q   <= {r_q[24:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            S_ROUND: begin
               r_valid <= 1'b1;
               r_out   <= r_spec ? r_spec_res : w_res;
               r_flags <= r_spec ? r_spec_flg : w_flg;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign valid   = r_valid;
   assign out_div = r_out;
   assign flags   = r_flags;

endmodule
